// File: rtl/nms_window_scheduler.sv
// Frame controller for the 5x5 NMS stage: raster-walks window centres, meters
// in-flight windows against a credit pool and buffers feature hits in a FWFT FIFO.
module nms_window_scheduler #(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 48,
    parameter int DATA_WIDTH = 46,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] cfg_threshold,
    output logic [DATA_WIDTH-1:0] nms_threshold,
    output logic                  win_req_valid,
    output logic [15:0]           win_req_addr,
    input  logic                  win_req_ready,
    output logic                  nms_ready,
    input  logic                  feat_valid,
    input  logic                  feat_isfeature,
    input  logic [15:0]           feat_addr,
    output logic                  out_valid,
    output logic [15:0]           out_addr,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           feature_count,
    output logic                  err_unexpected
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [7:0]    LAST_COL  = 8'(IMG_W - 3);
    localparam logic [7:0]    LAST_ROW  = 8'(IMG_H - 3);
    localparam logic [7:0]    FIRST_POS = 8'd2;
    localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   thr_q, thr_d;
    logic [7:0]              row_q, row_d;
    logic [7:0]              col_q, col_d;
    logic [CW-1:0]           inflight_q, inflight_d;
    logic [CW-1:0]           fifo_count_q, fifo_count_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [15:0]             feat_cnt_q, feat_cnt_d;
    logic                    err_q, err_d;
    logic [15:0]             mem_q [DEPTH];

    logic credit_ok;
    logic start_fire;
    logic req_fire;
    logic ret;
    logic push;
    logic pop;
    logic at_last;

    always_comb begin
        credit_ok  = (state_q == S_SCAN) &&
                     (({1'b0, inflight_q} + {1'b0, fifo_count_q}) < DEPTH_C);
        start_fire = (state_q == S_IDLE) && start;
        req_fire   = credit_ok && win_req_ready;
        ret        = feat_valid && (inflight_q != '0);
        push       = ret && feat_isfeature;
        pop        = (fifo_count_q != '0) && out_ready;
        at_last    = (row_q == LAST_ROW) && (col_q == LAST_COL);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_SCAN;
            S_SCAN:  if (req_fire && at_last) state_d = S_DRAIN;
            S_DRAIN: if ((inflight_q == '0) && (fifo_count_q == '0)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        thr_d        = thr_q;
        row_d        = row_q;
        col_d        = col_q;
        inflight_d   = inflight_q;
        fifo_count_d = fifo_count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        feat_cnt_d   = feat_cnt_q;
        err_d        = err_q;

        if (start_fire) begin
            thr_d      = cfg_threshold;
            row_d      = FIRST_POS;
            col_d      = FIRST_POS;
            feat_cnt_d = '0;
            err_d      = 1'b0;
        end else if (req_fire) begin
            if (col_q == LAST_COL) begin
                col_d = FIRST_POS;
                row_d = row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end

        // Issue and return cancel each other; likewise push and pop.
        case ({req_fire, ret})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        if (push && (feat_cnt_q != 16'hFFFF)) feat_cnt_d = feat_cnt_q + 16'd1;
        if (feat_valid && (inflight_q == '0)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            thr_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            inflight_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            feat_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            thr_q        <= thr_d;
            row_q        <= row_d;
            col_q        <= col_d;
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            feat_cnt_q   <= feat_cnt_d;
            err_q        <= err_d;
        end
    end

    // Storage is not reset; out_addr is gated so stale entries never leak out.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= feat_addr;
    end

    assign nms_threshold  = thr_q;
    assign win_req_valid  = credit_ok;
    assign nms_ready      = credit_ok;
    assign win_req_addr   = {row_q, col_q};
    assign out_valid      = (fifo_count_q != '0);
    assign out_addr       = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
    assign busy           = (state_q == S_SCAN) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign feature_count  = feat_cnt_q;
    assign err_unexpected = err_q;

endmodule
